// File: rtl/cpa_pkg.sv
// ---------------------------------------------------------------------------
// cpa_pkg
// Shared constants and types for the CPA ciphertext return path.
//   FRAME_HDR            : first byte of every frame, lets the host resync.
//   DEFAULT_CLKS_PER_BIT : 50 MHz system clock / 115200 baud.
//   state_e              : bit-level phase of the UART serialiser.
//   frame_bytes()        : bytes per frame (header + index + ciphertext).
// ---------------------------------------------------------------------------
package cpa_pkg;

   localparam logic [7:0] FRAME_HDR            = 8'hA5;
   localparam int         DEFAULT_CLKS_PER_BIT = 434;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   function automatic int frame_bytes(input int cypher_size);
      return 2 + cypher_size / 8;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// 8N1 serialiser for a single byte, LSB first, line idles high.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   start      : load data and begin a byte; honoured only while ready=1
//   data[7:0]  : byte to send, sampled when start is accepted
//   txd        : registered serial line
//   ready      : high while idle and on the final cycle of the stop bit, so
//                a start issued in that cycle chains bytes without a gap
// ---------------------------------------------------------------------------
module uart_tx_byte
   import cpa_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       txd,
   output logic       ready
);

   localparam int            TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_q,   bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          txd_q,   txd_d;
   logic          bit_end;

   assign bit_end = (timer_q == T_LAST);
   assign ready   = (state_q == IDLE) || ((state_q == STOP) && bit_end);
   assign txd     = txd_q;

   always_comb begin
      state_d = state_q;
      timer_d = bit_end ? '0 : timer_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      txd_d   = txd_q;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            txd_d   = 1'b1;
            if (start) begin
               state_d = START;
               shift_d = data;
               txd_d   = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               bit_d   = 3'd0;
               txd_d   = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  txd_d   = 1'b1;
               end else begin
                  // shift_q[0] is on the line now; the next bit is shift_q[1]
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  txd_d   = shift_q[1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (start) begin
                  state_d = START;
                  shift_d = data;
                  txd_d   = 1'b0;
               end else begin
                  state_d = IDLE;
                  txd_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

endmodule

// File: rtl/cpa_cipher_uart_tx.sv
// ---------------------------------------------------------------------------
// cpa_cipher_uart_tx
// Latches each AES ciphertext with its trace index and sends both to the host
// as one UART burst: 0xA5, trace_idx, ciphertext bytes MSB first.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset (aborts frame)
//   cipher_valid : one-cycle pulse qualifying cipher_text / trace_idx
//   cipher_text  : AES output block, CYPHER_SIZE bits
//   trace_idx    : index of the plaintext that produced the block
//   uart_txd     : 8N1 serial line, idle high
//   busy         : frame in progress
//   frames_sent  : completed frames, wraps 255 -> 0
//   overrun      : sticky, a block arrived while a frame was in progress
// ---------------------------------------------------------------------------
module cpa_cipher_uart_tx
   import cpa_pkg::*;
#(
   parameter int CYPHER_SIZE  = 128,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cipher_valid,
   input  logic [CYPHER_SIZE-1:0] cipher_text,
   input  logic [7:0]             trace_idx,
   output logic                   uart_txd,
   output logic                   busy,
   output logic [7:0]             frames_sent,
   output logic                   overrun
);

   localparam int             NBYTES = frame_bytes(CYPHER_SIZE);
   localparam int             BCW    = $clog2(NBYTES);
   localparam logic [BCW-1:0] BLAST  = BCW'(NBYTES - 1);

   logic                   busy_q,     busy_d;
   logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
   logic [7:0]             frames_q,   frames_d;
   logic                   overrun_q,  overrun_d;
   logic [CYPHER_SIZE-1:0] cipher_q,   cipher_d;
   logic [7:0]             trace_q,    trace_d;

   logic       accept, more, done;
   logic       tx_start, tx_ready;
   logic [7:0] tx_data;
   logic [7:0] frame_byte [2**BCW];

   // Frame image indexed by byte position; unused slots above NBYTES-1 are
   // zero so the power-of-two array can be indexed by byte_cnt_q directly.
   always_comb begin
      for (int k = 0; k < 2**BCW; k++) begin
         frame_byte[k] = 8'd0;
      end
      frame_byte[0] = FRAME_HDR;
      frame_byte[1] = trace_q;
      for (int k = 2; k < NBYTES; k++) begin
         frame_byte[k] = cipher_q[CYPHER_SIZE-1-8*(k-2) -: 8];
      end
   end

   // byte_cnt_q names the byte currently on the line; the next one is handed
   // over on the serialiser's last stop-bit cycle to keep bytes contiguous.
   assign accept   = cipher_valid && !busy_q;
   assign more     = busy_q && tx_ready && (byte_cnt_q != BLAST);
   assign done     = busy_q && tx_ready && (byte_cnt_q == BLAST);
   assign tx_start = accept || more;
   assign tx_data  = accept ? FRAME_HDR : frame_byte[byte_cnt_q + 1'b1];

   always_comb begin
      busy_d     = busy_q;
      byte_cnt_d = byte_cnt_q;
      frames_d   = frames_q;
      overrun_d  = overrun_q;
      cipher_d   = cipher_q;
      trace_d    = trace_q;
      if (accept) begin
         busy_d     = 1'b1;
         byte_cnt_d = '0;
         cipher_d   = cipher_text;
         trace_d    = trace_idx;
      end
      if (more) begin
         byte_cnt_d = byte_cnt_q + 1'b1;
      end
      if (done) begin
         busy_d   = 1'b0;
         frames_d = frames_q + 8'd1;
      end
      // includes the final stop-bit cycle: busy_q is still high there
      if (cipher_valid && busy_q) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q     <= 1'b0;
         byte_cnt_q <= '0;
         frames_q   <= 8'd0;
         overrun_q  <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         byte_cnt_q <= byte_cnt_d;
         frames_q   <= frames_d;
         overrun_q  <= overrun_d;
      end
   end

   // Payload holding registers carry no reset; they are only read while busy.
   always_ff @(posedge clk) begin
      cipher_q <= cipher_d;
      trace_q  <= trace_d;
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx (
      .clk   (clk),
      .reset (reset),
      .start (tx_start),
      .data  (tx_data),
      .txd   (uart_txd),
      .ready (tx_ready)
   );

   assign busy        = busy_q;
   assign frames_sent = frames_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_cpa_cipher_uart_tx.sv
module tb_cpa_cipher_uart_tx;

   localparam int CPB  = 4;
   localparam int NB   = 18;
   localparam int FLEN = NB * 10 * CPB;   // 720

   // small second instance used for the 256-frame wrap run
   localparam int CPB2  = 2;
   localparam int NB2   = 3;
   localparam int FLEN2 = NB2 * 10 * CPB2; // 60

   logic         clk;
   logic         reset;
   logic         cipher_valid;
   logic [127:0] cipher_text;
   logic [7:0]   trace_idx;
   logic         uart_txd;
   logic         busy;
   logic [7:0]   frames_sent;
   logic         overrun;

   logic         reset2;
   logic         cipher_valid2;
   logic [7:0]   cipher_text2;
   logic [7:0]   trace_idx2;
   logic         uart_txd2;
   logic         busy2;
   logic [7:0]   frames_sent2;
   logic         overrun2;

   int         n_tests;
   int         n_fail;
   logic [7:0] frames_exp;
   logic       ovr_exp;

   cpa_cipher_uart_tx #(
      .CYPHER_SIZE  (128),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cipher_valid (cipher_valid),
      .cipher_text  (cipher_text),
      .trace_idx    (trace_idx),
      .uart_txd     (uart_txd),
      .busy         (busy),
      .frames_sent  (frames_sent),
      .overrun      (overrun)
   );

   cpa_cipher_uart_tx #(
      .CYPHER_SIZE  (8),
      .CLKS_PER_BIT (CPB2)
   ) dut2 (
      .clk          (clk),
      .reset        (reset2),
      .cipher_valid (cipher_valid2),
      .cipher_text  (cipher_text2),
      .trace_idx    (trace_idx2),
      .uart_txd     (uart_txd2),
      .busy         (busy2),
      .frames_sent  (frames_sent2),
      .overrun      (overrun2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input int n);
      reset        = 1'b1;
      cipher_valid = 1'b0;
      repeat (n) @(negedge clk);
      reset      = 1'b0;
      frames_exp = 8'd0;
      ovr_exp    = 1'b0;
   endtask

   // Expected line level at cycle t of a frame (t=0 is the header start bit).
   function automatic logic line_level(input logic [7:0] bytes_m [NB], input int t);
      int b;
      int slot;
      b    = t / (10 * CPB);
      slot = (t % (10 * CPB)) / CPB;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return bytes_m[b][slot-1];
   endfunction

   // Called on a negative edge; returns on the negative edge after the frame
   // ends (first cycle busy is low) or after a mid-frame reset.
   task automatic run_frame(input logic [127:0] ct, input logic [7:0] idx,
                            input int ovr_at, input int rst_at, input string name);
      logic [7:0] bytes_m [NB];
      logic       wave [FLEN];
      logic [7:0] dec;
      int         busy_cnt;
      int         bad_cyc;
      bit         aborted;

      bytes_m[0] = 8'hA5;
      bytes_m[1] = idx;
      for (int k = 0; k < 16; k++) bytes_m[k+2] = ct[127-8*k -: 8];

      cipher_valid = 1'b1;
      cipher_text  = ct;
      trace_idx    = idx;
      @(negedge clk);
      cipher_valid = 1'b0;
      busy_cnt     = 0;
      aborted      = 1'b0;

      for (int t = 0; t < FLEN; t++) begin
         if (t == rst_at) begin
            reset = 1'b1;
            @(negedge clk);
            check_eq({name, "_rst_txd"},    32'(uart_txd),    32'd1);
            check_eq({name, "_rst_busy"},   32'(busy),        32'd0);
            check_eq({name, "_rst_frames"}, 32'(frames_sent), 32'd0);
            check_eq({name, "_rst_ovr"},    32'(overrun),     32'd0);
            reset      = 1'b0;
            frames_exp = 8'd0;
            ovr_exp    = 1'b0;
            aborted    = 1'b1;
            break;
         end
         wave[t] = uart_txd;
         if (busy) busy_cnt++;
         if (t == ovr_at) begin
            cipher_valid = 1'b1;
            cipher_text  = ~ct;
            trace_idx    = ~idx;
            ovr_exp      = 1'b1;
         end else begin
            cipher_valid = 1'b0;
         end
         @(negedge clk);
      end
      cipher_valid = 1'b0;

      if (!aborted) begin
         frames_exp++;
         bad_cyc = 0;
         for (int t = 0; t < FLEN; t++) begin
            if (wave[t] !== line_level(bytes_m, t)) bad_cyc++;
         end
         check_eq({name, "_wave_cycles"}, 32'(bad_cyc),     32'd0);
         check_eq({name, "_busy_len"},    32'(busy_cnt),    32'(FLEN));
         check_eq({name, "_busy_end"},    32'(busy),        32'd0);
         check_eq({name, "_txd_end"},     32'(uart_txd),    32'd1);
         check_eq({name, "_frames"},      32'(frames_sent), 32'(frames_exp));
         check_eq({name, "_overrun"},     32'(overrun),     32'(ovr_exp));
         for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < 8; i++) dec[i] = wave[b*10*CPB + (i+1)*CPB + CPB/2];
            check_eq($sformatf("%s_byte%0d", name, b), 32'(dec), 32'(bytes_m[b]));
         end
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic       w2 [FLEN2];
      logic [7:0] m2 [NB2];
      logic [7:0] dec2;
      logic [7:0] frames2_exp;
      int         bad2;

      n_tests       = 0;
      n_fail        = 0;
      frames_exp    = 8'd0;
      ovr_exp       = 1'b0;
      cipher_valid  = 1'b0;
      cipher_text   = '0;
      trace_idx     = 8'd0;
      reset2        = 1'b1;
      cipher_valid2 = 1'b0;
      cipher_text2  = 8'd0;
      trace_idx2    = 8'd0;
      reset         = 1'b1;
      @(negedge clk);

      // reset and idle line
      do_reset(3);
      for (int c = 0; c < 20; c++) begin
         check_eq("idle_txd",    32'(uart_txd),    32'd1);
         check_eq("idle_busy",   32'(busy),        32'd0);
         check_eq("idle_frames", 32'(frames_sent), 32'd0);
         check_eq("idle_ovr",    32'(overrun),     32'd0);
         @(negedge clk);
      end

      // known block, then a second frame on the first idle cycle
      run_frame(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 8'h05, -1, -1, "kat");
      run_frame(rnd128(), 8'($urandom), -1, -1, "b2b");

      // abort mid-frame, then a clean frame, then an overrun during a frame
      do_reset(2);
      run_frame(rnd128(), 8'($urandom), -1, 300, "abort");
      run_frame(rnd128(), 8'($urandom), -1, -1, "fresh");
      run_frame(rnd128(), 8'($urandom), 100, -1, "ovr");
      run_frame(rnd128(), 8'($urandom), FLEN - 1, -1, "ovr_last");
      run_frame(rnd128(), 8'($urandom), -1, -1, "sticky");

      // 256 back-to-back frames on the small instance: counter wraps to 0
      reset2      = 1'b0;
      frames2_exp = 8'd0;
      bad2        = 0;
      @(negedge clk);
      for (int f = 0; f < 256; f++) begin
         m2[0]         = 8'hA5;
         m2[1]         = 8'(f);
         m2[2]         = 8'($urandom);
         cipher_valid2 = 1'b1;
         cipher_text2  = m2[2];
         trace_idx2    = m2[1];
         @(negedge clk);
         cipher_valid2 = 1'b0;
         for (int t = 0; t < FLEN2; t++) begin
            w2[t] = uart_txd2;
            @(negedge clk);
         end
         frames2_exp++;
         for (int b = 0; b < NB2; b++) begin
            for (int i = 0; i < 8; i++) dec2[i] = w2[b*10*CPB2 + (i+1)*CPB2 + CPB2/2];
            if (b == 1) check_eq($sformatf("wrap_idx%0d", f), 32'(dec2), 32'(m2[1]));
            else if (dec2 !== m2[b]) bad2++;
         end
         if (busy2 !== 1'b0 || frames_sent2 !== frames2_exp) bad2++;
      end
      check_eq("wrap_other_errs", 32'(bad2),          32'd0);
      check_eq("wrap_frames",     32'(frames_sent2),  32'd0);
      check_eq("wrap_overrun",    32'(overrun2),      32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
